recon_checker: RTL and testbench

Downstream stage of the 9-pixel autoencoder datapath. Captures one 9-bit input pattern and the nine signed 20-bit sigmoid outputs produced for it, binarizes each output against a threshold, and walks the pixels sequentially to produce the reconstructed pattern, the Hamming error count and, optionally, an accumulated absolute error. Results are presented on a valid/ready output handshake so a host or test harness can consume one verdict per inference.

---
 rtl/recon_checker.sv | 124 ++++++++++++
 tb/tb_recon_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/recon_checker.sv
// recon_checker: binarizes nine sigmoid outputs, walks pixels to build recon and Hamming error.
// Optional RECON_ABSERR_EN compiles in the clamped absolute-error accumulator.
module recon_checker #(
    parameter int                 FRAC_BITS = 12,
    parameter logic signed [19:0] THRESH    = 20'sh00800
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [8:0]   x_in,
    input  logic [179:0] y_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [8:0]   recon,
    output logic [3:0]   err_count,
    output logic [15:0]  abs_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic   [3:0]        idx;
    logic   [8:0]        x_buf;
    logic   [179:0]      y_buf;
    logic signed [19:0]  ycur;
    logic                hit;

    // Buffers shift one pixel per SCAN cycle so the current pixel is always at bit/slot 0.
    assign ycur = y_buf[19:0];
    assign hit  = (ycur >= THRESH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            idx       <= 4'd0;
            recon     <= 9'd0;
            err_count <= 4'd0;
            x_buf     <= 9'd0;
            y_buf     <= 180'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_buf     <= x_in;
                        y_buf     <= y_in;
                        idx       <= 4'd0;
                        recon     <= 9'd0;
                        err_count <= 4'd0;
                        in_ready  <= 1'b0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    recon[idx] <= hit;
                    err_count  <= err_count + {3'b000, hit ^ x_buf[0]};
                    x_buf      <= x_buf >> 1;
                    y_buf      <= y_buf >> 20;
                    idx        <= idx + 4'd1;
                    if (idx == 4'd8) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef RECON_ABSERR_EN
    localparam int                ONE_I = 1 << FRAC_BITS;
    localparam logic signed [19:0] ONE  = ONE_I[19:0];

    logic [19:0] clamped;
    logic [19:0] target;
    logic [15:0] term;
    logic [15:0] acc;

    always_comb begin
        clamped = 20'd0;
        if (ycur < 0)
            clamped = 20'd0;
        else if (ycur > ONE)
            clamped = ONE;
        else
            clamped = ycur;
        target = x_buf[0] ? ONE : 20'd0;
        // Both operands lie in [0, ONE], so the difference fits easily in 16 bits.
        term = (clamped >= target) ? 16'(clamped - target)
                                   : 16'(target - clamped);
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc <= 16'd0;
        else if (state == IDLE && in_valid)
            acc <= 16'd0;
        else if (state == SCAN)
            acc <= acc + term;
    end

    assign abs_err = acc;
`else
    assign abs_err = 16'd0;
`endif

endmodule

// File: tb/tb_recon_checker.sv
// Directed self-checking bench for recon_checker.
// Expected abs_err follows RECON_ABSERR_EN; it is zero when the macro is undefined.
module tb_recon_checker;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [8:0]   x_in;
    logic [179:0] y_in;
    logic         out_valid;
    logic         out_ready;
    logic [8:0]   recon;
    logic [3:0]   err_count;
    logic [15:0]  abs_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    recon_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .recon     (recon),
        .err_count (err_count),
        .abs_err   (abs_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] absx(input int v);
`ifdef RECON_ABSERR_EN
        return v[15:0];
`else
        return (v == 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    function automatic logic [179:0] fill(input logic [19:0] v);
        logic [179:0] y;
        for (int i = 0; i < 9; i++) y[20*i +: 20] = v;
        return y;
    endfunction

    // Reference: threshold 0.5 (2048), ONE = 4096.
    function automatic void model(input logic [8:0] x, input logic [179:0] y,
                                  output logic [8:0] r, output logic [3:0] e,
                                  output logic [15:0] a);
        int s;
        int c;
        int t;
        logic signed [19:0] v;
        s = 0;
        e = 4'd0;
        r = 9'd0;
        for (int i = 0; i < 9; i++) begin
            v = y[20*i +: 20];
            r[i] = (int'(v) >= 2048);
            if (r[i] != x[i]) e = e + 4'd1;
            c = (int'(v) < 0) ? 0 : (int'(v) > 4096) ? 4096 : int'(v);
            t = c - (x[i] ? 4096 : 0);
            s += (t < 0) ? -t : t;
        end
        a = absx(s);
    endfunction

    task automatic accept(input logic [8:0] x, input logic [179:0] y);
        @(negedge clk);
        x_in     = x;
        y_in     = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [8:0] er,
                               input logic [3:0] ee, input logic [15:0] ea);
        int lat;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 10);
        chk({tag, "_recon"}, recon, er);
        chk({tag, "_err"}, err_count, ee);
        chk({tag, "_abs"}, abs_err, ea);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ov_drop"}, out_valid, 0);
        chk({tag, "_ir_rise"}, in_ready, 1);
    endtask

    logic [179:0] y3;
    logic [8:0]   px [5];
    logic [179:0] py [5];
    logic [8:0]   mr [5];
    logic [3:0]   me [5];
    logic [15:0]  ma [5];
    int           bad;
    int           p;
    int           r;
    int           last;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = 9'd0;
        y_in      = 180'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_recon", recon, 0);
        chk("rst_err", err_count, 0);
        chk("rst_abs", abs_err, 0);
        rst = 1'b0;

        // All ones, outputs exactly 1.0.
        accept(9'h1FF, fill(20'h01000));
        wait_result("ones", 9'h1FF, 4'd0, absx(0));
        handshake("ones");

        // All zero, outputs exactly at threshold.
        accept(9'h000, fill(20'h00800));
        wait_result("thresh", 9'h1FF, 4'd9, absx(18432));
        handshake("thresh");

        // Clamp case: 4*2047 + 3*2049 = 14335.
        y3 = fill(20'h007FF);
        y3[19:0]  = 20'hFF000;
        y3[39:20] = 20'h02000;
        accept(9'h0AA, y3);
        wait_result("clamp", 9'h002, 4'd3, absx(14335));
        handshake("clamp");

        // Reset in cycle N+4 of a scan.
        accept(9'h000, fill(20'h01000));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_recon", recon, 0);
        chk("mid_err", err_count, 0);
        chk("mid_abs", abs_err, 0);
        accept(9'h1FF, fill(20'h01000));
        wait_result("post_rst", 9'h1FF, 4'd0, absx(0));
        handshake("post_rst");

        // Backpressure for 20 cycles with in_valid pulses.
        accept(9'h0AA, y3);
        wait_result("bp", 9'h002, 4'd3, absx(14335));
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                recon !== 9'h002 || err_count !== 4'd3 ||
                abs_err !== absx(14335))
                bad++;
            in_valid = j[0];
            x_in     = 9'h155;
            y_in     = fill(20'h00000);
        end
        in_valid = 1'b0;
        chk("bp_stable", bad, 0);
        handshake("bp");
        @(negedge clk);
        chk("bp_no_ghost", in_ready, 1);

        // Back-to-back with in_valid and out_ready tied high.
        for (int i = 0; i < 5; i++) begin
            px[i] = 9'($urandom_range(0, 511));
            for (int k = 0; k < 9; k++)
                py[i][20*k +: 20] = 20'($urandom_range(0, 8191) - 2048);
            model(px[i], py[i], mr[i], me[i], ma[i]);
        end
        out_ready = 1'b1;
        p = 0;
        r = 0;
        last = 0;
        for (int cyc = 0; cyc < 100 && r < 5; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                chk("b2b_recon", recon, mr[r]);
                chk("b2b_err", err_count, me[r]);
                chk("b2b_abs", abs_err, ma[r]);
                if (r > 0) chk("b2b_period", cyc - last, 11);
                last = cyc;
                r++;
            end
            if (in_ready === 1'b1) begin
                if (p < 5) begin
                    x_in     = px[p];
                    y_in     = py[p];
                    in_valid = 1'b1;
                    p++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", r, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
